// File: rtl/buf_ram_arb_if.sv
// Requester, response and RAM-pin bundle for the two-client RAM arbiter.
interface buf_ram_arb_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          req0_valid;
  logic          req0_wen;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_ready;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid;
  logic          req1_wen;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ready;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;

  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  req0_valid, req0_wen, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_wen, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_wen, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req0_valid, req0_wen, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_wen, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_wen, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/buf_ram_arb.sv
// Two-client arbiter for one single-port sync-read RAM; one grant per cycle,
// round-robin (RR=1) or requester-0 fixed priority (RR=0), read data one cycle later.
module buf_ram_arb #(
  parameter int AW = 9,
  parameter int DW = 8,
  parameter int RR = 1
) (
  input logic           clk,
  input logic           rst,
  buf_ram_arb_if.slave  bus
);

  logic          gnt0;
  logic          gnt1;
  logic          last_gnt;
  logic          rd_pend0;
  logic          rd_pend1;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  // last_gnt==0 means requester 0 was served last, so 1 wins the next contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if ((RR != 0) && !last_gnt) gnt1 = 1'b1;
        else                        gnt0 = 1'b1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign addr_mux  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign wdata_mux = gnt1 ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.ram_wen    = (gnt0 && bus.req0_wen) || (gnt1 && bus.req1_wen);
  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      if (gnt0)      last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;
      rd_pend0 <= gnt0 && !bus.req0_wen;
      rd_pend1 <= gnt1 && !bus.req1_wen;
    end
  end

  // A read accepted just before reset rises must not report in the reset cycle.
  assign bus.rsp0_valid = rd_pend0 && !rst;
  assign bus.rsp1_valid = rd_pend1 && !rst;
  assign bus.rsp0_rdata = bus.ram_rdata;
  assign bus.rsp1_rdata = bus.ram_rdata;

endmodule

// File: tb/tb_buf_ram_arb.sv
// Directed bench: round-robin instance (ai) and fixed-priority instance (bi),
// each backed by a 512x8 read-before-write RAM model.
module tb_buf_ram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  buf_ram_arb_if #(.AW(9), .DW(8)) ai ();
  buf_ram_arb_if #(.AW(9), .DW(8)) bi ();

  buf_ram_arb #(.AW(9), .DW(8), .RR(1)) u_rr (.clk(clk), .rst(rst), .bus(ai));
  buf_ram_arb #(.AW(9), .DW(8), .RR(0)) u_fp (.clk(clk), .rst(rst), .bus(bi));

  logic [7:0] mem_a [512];
  logic [7:0] mem_b [512];

  always @(posedge clk) begin
    ai.ram_rdata <= mem_a[ai.ram_addr];
    if (ai.ram_wen) mem_a[ai.ram_addr] <= ai.ram_wdata;
  end

  always @(posedge clk) begin
    bi.ram_rdata <= mem_b[bi.ram_addr];
    if (bi.ram_wen) mem_b[bi.ram_addr] <= bi.ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a0(input logic v, input logic w, input logic [8:0] ad, input logic [7:0] d);
    ai.req0_valid = v; ai.req0_wen = w; ai.req0_addr = ad; ai.req0_wdata = d;
  endtask

  task automatic a1(input logic v, input logic w, input logic [8:0] ad, input logic [7:0] d);
    ai.req1_valid = v; ai.req1_wen = w; ai.req1_addr = ad; ai.req1_wdata = d;
  endtask

  task automatic b0(input logic v, input logic w, input logic [8:0] ad, input logic [7:0] d);
    bi.req0_valid = v; bi.req0_wen = w; bi.req0_addr = ad; bi.req0_wdata = d;
  endtask

  task automatic b1(input logic v, input logic w, input logic [8:0] ad, input logic [7:0] d);
    bi.req1_valid = v; bi.req1_wen = w; bi.req1_addr = ad; bi.req1_wdata = d;
  endtask

  // Inputs change just after the falling edge; combinational outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    a0(1'b1, 1'b1, 9'h010, 8'hEE);
    a1(1'b0, 1'b0, 9'h000, 8'h00);
    b0(1'b0, 1'b0, 9'h000, 8'h00);
    b1(1'b0, 1'b0, 9'h000, 8'h00);

    // Reset: valid write held but never accepted
    step(); #1;
    chk("rst_ready0", 32'(ai.req0_ready), 32'd0);
    chk("rst_ram_wen", 32'(ai.ram_wen), 32'd0);
    chk("rst_rsp0", 32'(ai.rsp0_valid), 32'd0);
    chk("rst_rsp1", 32'(ai.rsp1_valid), 32'd0);
    step(); #1;
    chk("rst2_ready0", 32'(ai.req0_ready), 32'd0);

    // Single writer/reader; first cycle out of reset grants immediately
    step(); rst = 1'b0; a0(1'b1, 1'b1, 9'h010, 8'hA5); #1;
    chk("wr_ready0", 32'(ai.req0_ready), 32'd1);
    chk("wr_ram_wen", 32'(ai.ram_wen), 32'd1);
    chk("wr_ram_addr", 32'(ai.ram_addr), 32'h010);
    chk("wr_ram_wdata", 32'(ai.ram_wdata), 32'hA5);
    step(); a0(1'b0, 1'b0, 9'h000, 8'h00); a1(1'b1, 1'b0, 9'h010, 8'h00); #1;
    chk("rd_ready1", 32'(ai.req1_ready), 32'd1);
    chk("rd_ram_wen", 32'(ai.ram_wen), 32'd0);
    chk("rd_rsp0_none", 32'(ai.rsp0_valid), 32'd0);
    step(); a1(1'b0, 1'b0, 9'h000, 8'h00); #1;
    chk("rd_rsp1_valid", 32'(ai.rsp1_valid), 32'd1);
    chk("rd_rsp1_data", 32'(ai.rsp1_rdata), 32'hA5);
    chk("rd_rsp0_still0", 32'(ai.rsp0_valid), 32'd0);

    // Preload; last writer is requester 1 so requester 0 wins next contention
    step(); a0(1'b1, 1'b1, 9'h1FF, 8'h77); #1;
    step(); a0(1'b1, 1'b1, 9'h1FE, 8'h66); #1;
    step(); a0(1'b1, 1'b1, 9'h000, 8'h11); #1;
    step(); a0(1'b0, 1'b0, 9'h000, 8'h00); a1(1'b1, 1'b1, 9'h001, 8'h22); #1;
    chk("pre_ready1", 32'(ai.req1_ready), 32'd1);

    // Round-robin contention: 0,1,0,1,0,1 with responses a cycle behind
    step(); a0(1'b1, 1'b0, 9'h000, 8'h00); a1(1'b1, 1'b0, 9'h001, 8'h00); #1;
    chk("rr0_ready0", 32'(ai.req0_ready), 32'd1);
    chk("rr0_ready1", 32'(ai.req1_ready), 32'd0);
    chk("rr0_rsp0", 32'(ai.rsp0_valid), 32'd0);
    for (int k = 1; k < 6; k++) begin
      step(); #1;
      chk($sformatf("rr%0d_ready0", k), 32'(ai.req0_ready), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_ready1", k), 32'(ai.req1_ready), 32'((k % 2) == 1));
      if ((k % 2) == 1) begin
        chk($sformatf("rr%0d_rsp0", k), 32'(ai.rsp0_valid), 32'd1);
        chk($sformatf("rr%0d_rdata0", k), 32'(ai.rsp0_rdata), 32'h11);
        chk($sformatf("rr%0d_rsp1", k), 32'(ai.rsp1_valid), 32'd0);
      end else begin
        chk($sformatf("rr%0d_rsp1", k), 32'(ai.rsp1_valid), 32'd1);
        chk($sformatf("rr%0d_rdata1", k), 32'(ai.rsp1_rdata), 32'h22);
        chk($sformatf("rr%0d_rsp0", k), 32'(ai.rsp0_valid), 32'd0);
      end
    end

    // Back-to-back reads from requester 0 (first one also closes the RR run)
    step(); a1(1'b0, 1'b0, 9'h000, 8'h00); a0(1'b1, 1'b0, 9'h1FF, 8'h00); #1;
    chk("rr6_rsp1", 32'(ai.rsp1_valid), 32'd1);
    chk("rr6_rdata1", 32'(ai.rsp1_rdata), 32'h22);
    chk("b2b0_ready0", 32'(ai.req0_ready), 32'd1);
    chk("b2b0_wen", 32'(ai.ram_wen), 32'd0);
    step(); a0(1'b1, 1'b0, 9'h000, 8'h00); #1;
    chk("b2b1_rsp0", 32'(ai.rsp0_valid), 32'd1);
    chk("b2b1_rdata", 32'(ai.rsp0_rdata), 32'h77);
    chk("b2b1_wen", 32'(ai.ram_wen), 32'd0);
    step(); a0(1'b1, 1'b0, 9'h1FE, 8'h00); #1;
    chk("b2b2_rsp0", 32'(ai.rsp0_valid), 32'd1);
    chk("b2b2_rdata", 32'(ai.rsp0_rdata), 32'h11);
    chk("b2b2_wen", 32'(ai.ram_wen), 32'd0);
    step(); a0(1'b0, 1'b0, 9'h000, 8'h00); #1;
    chk("b2b3_rsp0", 32'(ai.rsp0_valid), 32'd1);
    chk("b2b3_rdata", 32'(ai.rsp0_rdata), 32'h66);
    step(); #1;
    chk("b2b4_rsp0", 32'(ai.rsp0_valid), 32'd0);

    // Write by 1 at T, read of same address by 0 at T+1 sees the new data
    step(); a1(1'b1, 1'b1, 9'h080, 8'h3C); #1;
    chk("wtr_ready1", 32'(ai.req1_ready), 32'd1);
    chk("wtr_wen", 32'(ai.ram_wen), 32'd1);
    step(); a1(1'b0, 1'b0, 9'h000, 8'h00); a0(1'b1, 1'b0, 9'h080, 8'h00); #1;
    chk("wtr_ready0", 32'(ai.req0_ready), 32'd1);
    chk("wtr_rsp1_none", 32'(ai.rsp1_valid), 32'd0);
    step(); a0(1'b0, 1'b0, 9'h000, 8'h00); #1;
    chk("wtr_rsp0", 32'(ai.rsp0_valid), 32'd1);
    chk("wtr_rdata", 32'(ai.rsp0_rdata), 32'h3C);

    // Reset mid-operation: read accepted at T, reset at T+1 suppresses response
    step(); a0(1'b1, 1'b0, 9'h010, 8'h00); #1;
    chk("mid_ready0", 32'(ai.req0_ready), 32'd1);
    step(); rst = 1'b1; a1(1'b1, 1'b0, 9'h001, 8'h00); a0(1'b1, 1'b1, 9'h010, 8'h99); #1;
    chk("mid_rsp0", 32'(ai.rsp0_valid), 32'd0);
    chk("mid_ready0_rst", 32'(ai.req0_ready), 32'd0);
    chk("mid_ready1_rst", 32'(ai.req1_ready), 32'd0);
    chk("mid_wen_rst", 32'(ai.ram_wen), 32'd0);
    step(); #1;
    chk("mid2_rsp0", 32'(ai.rsp0_valid), 32'd0);
    chk("mid2_wen_rst", 32'(ai.ram_wen), 32'd0);
    step(); rst = 1'b0; a0(1'b1, 1'b0, 9'h010, 8'h00); #1;
    chk("post_ready0", 32'(ai.req0_ready), 32'd1);
    chk("post_ready1", 32'(ai.req1_ready), 32'd0);
    step(); a0(1'b0, 1'b0, 9'h000, 8'h00); a1(1'b0, 1'b0, 9'h000, 8'h00); #1;
    chk("post_rsp0", 32'(ai.rsp0_valid), 32'd1);
    chk("post_rdata0", 32'(ai.rsp0_rdata), 32'hA5);

    // Fixed priority: requester 0 served last, yet still wins every contention
    step(); b0(1'b1, 1'b0, 9'h000, 8'h00); #1;
    chk("fp_solo_ready0", 32'(bi.req0_ready), 32'd1);
    step(); b1(1'b1, 1'b0, 9'h001, 8'h00); #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        step(); #1;
      end
      chk($sformatf("fp%0d_ready0", k), 32'(bi.req0_ready), 32'd1);
      chk($sformatf("fp%0d_ready1", k), 32'(bi.req1_ready), 32'd0);
    end
    step(); b0(1'b0, 1'b0, 9'h000, 8'h00); #1;
    chk("fp_drop_ready1", 32'(bi.req1_ready), 32'd1);
    chk("fp_drop_ready0", 32'(bi.req0_ready), 32'd0);
    step(); b1(1'b0, 1'b0, 9'h000, 8'h00); #1;
    chk("fp_rsp1", 32'(bi.rsp1_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
